matrix_print_engine: RTL and testbench

Parametrised successor to the single-size traverse/print path. It scans the matrix store and selects matrices by one of three modes: a single index, all matrices of one size, or every stored matrix. Each selected matrix is rendered as ASCII decimal text and streamed byte-by-byte over a valid/ready interface to the UART transmitter. It replaces the fixed-width, fixed-buffer bridge and traverse controller pair with one block generic in data width, store depth and matrix count.

---
 rtl/matrix_pkg.sv | 43 ++++
 rtl/matrix_print_engine_bin2bcd_seq.sv | 70 +++++++
 rtl/matrix_print_engine.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_matrix_print_engine.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared encodings, ASCII constants and state type for the matrix print engine.
package matrix_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SIZE   = 2'd1;
    localparam logic [1:0] MODE_ALL    = 2'd2;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int DIM_W = 3;

    // Decimal digits needed for the largest unsigned value of the given width.
    function automatic int dec_digits(input int width);
        longint maxVal;
        int     digits;
        maxVal = (longint'(1) << width) - 1;
        digits = 1;
        for (int i = 0; i < 20; i++) begin
            if (maxVal >= 10) begin
                maxVal = maxVal / 10;
                digits++;
            end
        end
        return digits;
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SCAN,
        ST_CNT_CONV,
        ST_CNT_EMIT,
        ST_FIND,
        ST_READ,
        ST_CONV,
        ST_EMIT_DIG,
        ST_EMIT_SEP,
        ST_FIN
    } state_t;

endpackage

// File: rtl/matrix_print_engine_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, WIDTH cycles from start to done.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The start cycle already performs the first shift, since an all-zero BCD needs no adjust.
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start_i && !busy_q) begin
            bcd_d   = (4*DIGITS)'(bin_i[WIDTH-1]);
            shift_d = bin_i << 1;
            cnt_d   = CW'(WIDTH - 1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            bcd_d   = (adj << 1) | (4*DIGITS)'(shift_q[WIDTH-1]);
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/matrix_print_engine.sv
// Selects stored matrices by index, size or all, and streams them as ASCII
// decimal text over a valid/ready byte interface.
module matrix_print_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_SIZE   = 5,
    parameter int MATRIX_NUM = 8,
    parameter int IDX_W      = 3,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [IDX_W-1:0]      req_idx_i,
    input  logic [2:0]            req_row_i,
    input  logic [2:0]            req_col_i,
    output logic [IDX_W-1:0]      meta_idx_o,
    input  logic                  meta_valid_i,
    input  logic [2:0]            meta_row_i,
    input  logic [2:0]            meta_col_i,
    output logic                  rd_en_o,
    output logic [IDX_W-1:0]      rd_idx_o,
    output logic [ADDR_W-1:0]     rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [IDX_W:0]        printed_cnt_o
);

    import matrix_pkg::*;

    localparam int CNT_W  = IDX_W + 1;
    localparam int CONV_W = (DATA_WIDTH > CNT_W) ? DATA_WIDTH : CNT_W;
    localparam int DIGITS = dec_digits(CONV_W);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] PTR_LAST = CNT_W'(MATRIX_NUM - 1);
    localparam logic [CNT_W-1:0] PTR_END  = CNT_W'(MATRIX_NUM);

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [IDX_W-1:0]     reqIdx_q, reqIdx_d;
    logic [DIM_W-1:0]     reqRow_q, reqRow_d, reqCol_q, reqCol_d;
    logic [CNT_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     matchCnt_q, matchCnt_d;
    logic [CNT_W-1:0]     printed_q, printed_d;
    logic                 err_q, err_d;
    logic [DIM_W-1:0]     row_q, row_d, col_q, col_d;
    logic [DIM_W-1:0]     metaRow_q, metaRow_d, metaCol_q, metaCol_d;
    logic [DIG_W-1:0]     digIdx_q, digIdx_d;
    logic                 digStarted_q, digStarted_d;
    logic                 cntSep_q, cntSep_d;
    logic [1:0]           sepStep_q, sepStep_d;

    logic                 bcdStart, bcdBusy, bcdDone;
    logic [CONV_W-1:0]    bcdBin;
    logic [4*DIGITS-1:0]  bcdVal;
    logic [DIG_W-1:0]     firstDig, curDig;
    logic [7:0]           digitChar;
    logic                 sizeOk, slotMatch, lastCol, lastRow;
    logic [1:0]           sepLast;

    assign bcdBin = (state_q == ST_CNT_CONV) ? CONV_W'(matchCnt_q) : CONV_W'(rd_data_i);

    bin2bcd_seq #(
        .WIDTH  (CONV_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (bcdStart),
        .bin_i   (bcdBin),
        .busy_o  (bcdBusy),
        .done_o  (bcdDone),
        .bcd_o   (bcdVal)
    );

    // Slots whose stored size is empty or beyond MAX_SIZE can never be printed.
    always_comb begin
        sizeOk = (meta_row_i != '0) && (meta_col_i != '0) &&
                 (int'(meta_row_i) <= MAX_SIZE) && (int'(meta_col_i) <= MAX_SIZE);
        slotMatch = 1'b0;
        case (mode_q)
            MODE_SINGLE: slotMatch = meta_valid_i && sizeOk && (ptr_q[IDX_W-1:0] == reqIdx_q);
            MODE_SIZE:   slotMatch = meta_valid_i && sizeOk &&
                                     (meta_row_i == reqRow_q) && (meta_col_i == reqCol_q);
            MODE_ALL:    slotMatch = meta_valid_i && sizeOk;
            default:     slotMatch = 1'b0;
        endcase
    end

    // Until the first digit goes out, the index is the highest nonzero digit (0 for value 0).
    always_comb begin
        firstDig = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcdVal[4*i +: 4] != 4'd0) begin
                firstDig = DIG_W'(i);
            end
        end
        curDig    = digStarted_q ? digIdx_q : firstDig;
        digitChar = ASCII_ZERO + {4'd0, bcdVal[4*curDig +: 4]};
    end

    assign lastCol = (col_q == (metaCol_q - 1'b1));
    assign lastRow = (row_q == (metaRow_q - 1'b1));
    assign sepLast = !lastCol ? 2'd0 : (lastRow ? 2'd3 : 2'd1);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        reqIdx_d     = reqIdx_q;
        reqRow_d     = reqRow_q;
        reqCol_d     = reqCol_q;
        ptr_d        = ptr_q;
        matchCnt_d   = matchCnt_q;
        printed_d    = printed_q;
        err_d        = err_q;
        row_d        = row_q;
        col_d        = col_q;
        metaRow_d    = metaRow_q;
        metaCol_d    = metaCol_q;
        digIdx_d     = digIdx_q;
        digStarted_d = digStarted_q;
        cntSep_d     = cntSep_q;
        sepStep_d    = sepStep_q;
        bcdStart     = 1'b0;
        rd_en_o      = 1'b0;
        tx_valid_o   = 1'b0;
        tx_data_o    = '0;
        done_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d     = mode_i;
                    reqIdx_d   = req_idx_i;
                    reqRow_d   = req_row_i;
                    reqCol_d   = req_col_i;
                    err_d      = 1'b0;
                    printed_d  = '0;
                    matchCnt_d = '0;
                    ptr_d      = '0;
                    state_d    = ST_SCAN;
                    if (mode_i == 2'd3) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_SCAN: begin
                if (slotMatch) begin
                    matchCnt_d = matchCnt_q + 1'b1;
                end
                if (ptr_q == PTR_LAST) begin
                    ptr_d = '0;
                    if (mode_q != MODE_SINGLE) begin
                        state_d = ST_CNT_CONV;
                    end else if (!slotMatch && (matchCnt_q == '0)) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_FIND;
                    end
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_CNT_CONV: begin
                bcdStart = !bcdBusy;
                if (bcdDone) begin
                    digStarted_d = 1'b0;
                    cntSep_d     = 1'b0;
                    sepStep_d    = '0;
                    state_d      = ST_CNT_EMIT;
                end
            end
            ST_CNT_EMIT: begin
                tx_valid_o = 1'b1;
                tx_data_o  = !cntSep_q ? digitChar : (sepStep_q[0] ? ASCII_LF : ASCII_CR);
                if (tx_ready_i) begin
                    if (!cntSep_q) begin
                        if (curDig == '0) begin
                            cntSep_d = 1'b1;
                        end else begin
                            digIdx_d     = curDig - 1'b1;
                            digStarted_d = 1'b1;
                        end
                    end else if (sepStep_q == 2'd0) begin
                        sepStep_d = 2'd1;
                    end else begin
                        state_d = (matchCnt_q == '0) ? ST_FIN : ST_FIND;
                    end
                end
            end
            ST_FIND: begin
                if (ptr_q >= PTR_END) begin
                    state_d = ST_FIN;
                end else if (slotMatch) begin
                    metaRow_d = meta_row_i;
                    metaCol_d = meta_col_i;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = ST_READ;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READ: begin
                rd_en_o = 1'b1;
                state_d = ST_CONV;
            end
            ST_CONV: begin
                bcdStart = !bcdBusy;
                if (bcdDone) begin
                    digStarted_d = 1'b0;
                    state_d      = ST_EMIT_DIG;
                end
            end
            ST_EMIT_DIG: begin
                tx_valid_o = 1'b1;
                tx_data_o  = digitChar;
                if (tx_ready_i) begin
                    if (curDig == '0) begin
                        sepStep_d = '0;
                        state_d   = ST_EMIT_SEP;
                    end else begin
                        digIdx_d     = curDig - 1'b1;
                        digStarted_d = 1'b1;
                    end
                end
            end
            // Separator run: one space mid-row, CR LF at row end, CR LF CR LF after the last row.
            ST_EMIT_SEP: begin
                tx_valid_o = 1'b1;
                tx_data_o  = !lastCol ? ASCII_SPACE : (sepStep_q[0] ? ASCII_LF : ASCII_CR);
                if (tx_ready_i) begin
                    if (sepStep_q != sepLast) begin
                        sepStep_d = sepStep_q + 1'b1;
                    end else if (!lastCol) begin
                        col_d   = col_q + 1'b1;
                        state_d = ST_READ;
                    end else if (!lastRow) begin
                        col_d   = '0;
                        row_d   = row_q + 1'b1;
                        state_d = ST_READ;
                    end else begin
                        printed_d = printed_q + 1'b1;
                        if ((printed_q + 1'b1) == matchCnt_q) begin
                            state_d = ST_FIN;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            state_d = ST_FIND;
                        end
                    end
                end
            end
            ST_FIN: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            reqIdx_q     <= '0;
            reqRow_q     <= '0;
            reqCol_q     <= '0;
            ptr_q        <= '0;
            matchCnt_q   <= '0;
            printed_q    <= '0;
            err_q        <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            metaRow_q    <= '0;
            metaCol_q    <= '0;
            digIdx_q     <= '0;
            digStarted_q <= 1'b0;
            cntSep_q     <= 1'b0;
            sepStep_q    <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            reqIdx_q     <= reqIdx_d;
            reqRow_q     <= reqRow_d;
            reqCol_q     <= reqCol_d;
            ptr_q        <= ptr_d;
            matchCnt_q   <= matchCnt_d;
            printed_q    <= printed_d;
            err_q        <= err_d;
            row_q        <= row_d;
            col_q        <= col_d;
            metaRow_q    <= metaRow_d;
            metaCol_q    <= metaCol_d;
            digIdx_q     <= digIdx_d;
            digStarted_q <= digStarted_d;
            cntSep_q     <= cntSep_d;
            sepStep_q    <= sepStep_d;
        end
    end

    assign meta_idx_o    = ptr_q[IDX_W-1:0];
    assign rd_idx_o      = ptr_q[IDX_W-1:0];
    assign rd_addr_o     = ADDR_W'(row_q) * ADDR_W'(metaCol_q) + ADDR_W'(col_q);
    assign busy_o        = (state_q != ST_IDLE);
    assign err_o         = err_q;
    assign printed_cnt_o = printed_q;

endmodule

// File: tb/tb_matrix_print_engine.sv
// Scoreboard bench for matrix_print_engine: expected bytes are queued per request, a monitor pops them.
module tb_matrix_print_engine;

    localparam int DATA_WIDTH = 8;
    localparam int MAX_SIZE   = 5;
    localparam int MATRIX_NUM = 8;
    localparam int IDX_W      = 3;
    localparam int ADDR_W     = 5;
    localparam int WAIT_LIMIT = 3000;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [1:0]            mode;
    logic [IDX_W-1:0]      reqIdx;
    logic [2:0]            reqRow, reqCol;
    logic [IDX_W-1:0]      metaIdx;
    logic                  metaValid;
    logic [2:0]            metaRow, metaCol;
    logic                  rdEn;
    logic [IDX_W-1:0]      rdIdx;
    logic [ADDR_W-1:0]     rdAddr;
    logic [DATA_WIDTH-1:0] rdData;
    logic [7:0]            txData;
    logic                  txValid, txReady;
    logic                  busy, done, err;
    logic [IDX_W:0]        printedCnt;

    logic                  storeValid [MATRIX_NUM];
    logic [2:0]            storeRow   [MATRIX_NUM];
    logic [2:0]            storeCol   [MATRIX_NUM];
    logic [7:0]            storeMem   [MATRIX_NUM][32];

    logic [7:0]            expQ[$];
    int                    checks   = 0;
    int                    failures = 0;
    bit                    stallMode = 0;

    matrix_print_engine #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_SIZE   (MAX_SIZE),
        .MATRIX_NUM (MATRIX_NUM),
        .IDX_W      (IDX_W),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .mode_i        (mode),
        .req_idx_i     (reqIdx),
        .req_row_i     (reqRow),
        .req_col_i     (reqCol),
        .meta_idx_o    (metaIdx),
        .meta_valid_i  (metaValid),
        .meta_row_i    (metaRow),
        .meta_col_i    (metaCol),
        .rd_en_o       (rdEn),
        .rd_idx_o      (rdIdx),
        .rd_addr_o     (rdAddr),
        .rd_data_i     (rdData),
        .tx_data_o     (txData),
        .tx_valid_o    (txValid),
        .tx_ready_i    (txReady),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .printed_cnt_o (printedCnt)
    );

    assign metaValid = storeValid[metaIdx];
    assign metaRow   = storeRow[metaIdx];
    assign metaCol   = storeCol[metaIdx];

    always @(posedge clk) begin
        if (rdEn) rdData <= storeMem[rdIdx][rdAddr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        txReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            txReady = stallMode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        expQ.push_back(b);
    endtask

    task automatic pushCrLf();
        pushByte(8'h0D);
        pushByte(8'h0A);
    endtask

    task automatic pushNum(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) pushByte(s[i]);
    endtask

    task automatic pushMatrix(input int s);
        int rows, cols;
        rows = int'(storeRow[s]);
        cols = int'(storeCol[s]);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                pushNum(int'(storeMem[s][r*cols + c]));
                if (c < cols - 1) pushByte(8'h20);
                else pushCrLf();
            end
        end
        pushCrLf();
    endtask

    task automatic setSlot(input int s, input int rows, input int cols);
        storeValid[s] = 1'b1;
        storeRow[s]   = 3'(rows);
        storeCol[s]   = 3'(cols);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input int idx, input int r, input int c);
        @(posedge clk);
        #1;
        mode   = m;
        reqIdx = IDX_W'(idx);
        reqRow = 3'(r);
        reqCol = 3'(c);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic waitDone(input string name, input int expErr, input int expPrinted);
        bit seen;
        seen = 0;
        for (int i = 0; i < WAIT_LIMIT && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            checkOutput({name, "_busy_at_done"}, 32'(busy), 1);
            checkOutput({name, "_err"}, 32'(err), 32'(expErr));
            checkOutput({name, "_printed"}, 32'(printedCnt), 32'(expPrinted));
            checkOutput({name, "_bytes_left"}, 32'(expQ.size()), 0);
            @(negedge clk);
            checkOutput({name, "_done_pulse"}, 32'(done), 0);
            checkOutput({name, "_idle"}, 32'(busy), 0);
        end
        expQ.delete();
    endtask

    // Monitor: pops one expected byte per transfer, and checks held data during stalls.
    initial begin
        logic [7:0] held;
        logic       wasStalled;
        logic [7:0] want;
        wasStalled = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wasStalled = 1'b0;
            end else begin
                if (wasStalled) begin
                    checkOutput("stall_valid_held", 32'(txValid), 1);
                    checkOutput("stall_data_held", 32'(txData), 32'(held));
                end
                if (txValid && txReady) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_byte actual=%0d required=none", txData);
                    end else begin
                        want = expQ.pop_front();
                        checkOutput("tx_byte", 32'(txData), 32'(want));
                    end
                end
                wasStalled = txValid && !txReady;
                held       = txData;
            end
        end
    end

    initial begin
        int got;
        rst_n  = 1'b1;
        start  = 1'b0;
        mode   = '0;
        reqIdx = '0;
        reqRow = '0;
        reqCol = '0;
        for (int s = 0; s < MATRIX_NUM; s++) begin
            storeValid[s] = 1'b0;
            storeRow[s]   = '0;
            storeCol[s]   = '0;
            for (int a = 0; a < 32; a++) storeMem[s][a] = '0;
        end
        setSlot(2, 2, 2);
        storeMem[2][0] = 8'd0;
        storeMem[2][1] = 8'd7;
        storeMem[2][2] = 8'd10;
        storeMem[2][3] = 8'd255;
        setSlot(1, 2, 2);
        for (int k = 0; k < 4; k++) storeMem[1][k] = 8'(k + 1);
        setSlot(0, 3, 3);
        setSlot(3, 3, 3);
        setSlot(5, 3, 3);
        for (int k = 0; k < 9; k++) begin
            storeMem[0][k] = 8'(k * 11);
            storeMem[3][k] = 8'(100 + k);
            storeMem[5][k] = 8'(250 - k);
        end

        #2 rst_n = 1'b0;
        #10;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_tx_valid", 32'(txValid), 0);
        checkOutput("reset_tx_data", 32'(txData), 0);
        checkOutput("reset_rd_en", 32'(rdEn), 0);
        checkOutput("reset_printed", 32'(printedCnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single index, slot 2");
        pushMatrix(2);
        applyStimulus(2'd0, 2, 0, 0);
        waitDone("single", 0, 1);

        $display("[TB] all of size 3x3");
        pushNum(3);
        pushCrLf();
        pushMatrix(0);
        pushMatrix(3);
        pushMatrix(5);
        applyStimulus(2'd1, 0, 3, 3);
        waitDone("size3", 0, 3);

        $display("[TB] size 4x4, none stored");
        pushNum(0);
        pushCrLf();
        applyStimulus(2'd1, 0, 4, 4);
        waitDone("size4_none", 0, 0);

        $display("[TB] single index on empty slot");
        applyStimulus(2'd0, 6, 0, 0);
        waitDone("empty_slot", 1, 0);

        $display("[TB] all stored");
        pushNum(5);
        pushCrLf();
        pushMatrix(0);
        pushMatrix(1);
        pushMatrix(2);
        pushMatrix(3);
        pushMatrix(5);
        applyStimulus(2'd2, 0, 0, 0);
        waitDone("all", 0, 5);

        $display("[TB] reserved mode");
        applyStimulus(2'd3, 0, 0, 0);
        waitDone("reserved", 1, 0);

        $display("[TB] 5x5 of 200 with random ready stalls");
        setSlot(7, 5, 5);
        for (int k = 0; k < 25; k++) storeMem[7][k] = 8'd200;
        stallMode = 1;
        pushMatrix(7);
        applyStimulus(2'd0, 7, 0, 0);
        waitDone("stall", 0, 1);
        stallMode = 0;

        $display("[TB] reset mid-element");
        pushMatrix(7);
        applyStimulus(2'd0, 7, 0, 0);
        got = 0;
        for (int i = 0; i < WAIT_LIMIT && got < 10; i++) begin
            @(negedge clk);
            if (txValid && txReady) got++;
        end
        checkOutput("midreset_progress", 32'(got), 10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_tx_valid", 32'(txValid), 0);
        checkOutput("midreset_tx_data", 32'(txData), 0);
        checkOutput("midreset_rd_en", 32'(rdEn), 0);
        checkOutput("midreset_done", 32'(done), 0);
        expQ.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] restart after reset, with an ignored start while busy");
        pushMatrix(2);
        applyStimulus(2'd0, 2, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        mode  = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("after_reset", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
